// File: rtl/fetch_sequencer.sv
// Program-ROM fetch sequencer: owns the PC, registers each ROM word into a
// one-entry output stage and hands it to execute with a pre-decoded class.
module fetch_sequencer #(
   parameter int unsigned PROG_LEN = 7,
   parameter bit          WRAP     = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_jump,
   input  logic [15:0] i_jump_addr,
   output logic [15:0] o_rom_addr,
   input  logic [17:0] i_rom_data,
   output logic [17:0] o_instr,
   output logic [1:0]  o_class,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_pc_out,
   output logic        o_done,
   output logic [15:0] o_count,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [15:0] LEN  = 16'(PROG_LEN);
   localparam logic [15:0] LAST = 16'(PROG_LEN - 1);

   // Handshake: a word moves to execute in every cycle where o_valid and
   // i_ready are both high; o_valid never drops without an accept, a jump
   // flush or reset, and o_instr is stable while o_valid is high and unaccepted.

   logic [1:0]  state;
   logic [15:0] pc;
   logic        fetch;
   logic        accept;
   logic        jump_take;
   logic        pc_out_of_range;

   always_comb begin
      pc_out_of_range = (pc >= LEN);
      accept          = o_valid && i_ready;
      jump_take       = i_jump && ((state == ST_RUN) || (state == ST_DONE));
      fetch           = (state == ST_RUN) && !i_pause && !i_jump &&
                        !pc_out_of_range && (!o_valid || i_ready);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         pc       <= 16'd0;
         o_valid  <= 1'b0;
         o_instr  <= 18'd0;
         o_pc_out <= 16'd0;
         o_count  <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state <= ST_RUN;
                  pc    <= 16'd0;
               end
            end
            ST_RUN: begin
               // An out-of-range PC (end of program or a jump past it) parks in
               // DONE; with WRAP set only a jump can produce one.
               if (!i_jump && pc_out_of_range) state <= ST_DONE;
            end
            ST_DONE: begin
               if (i_jump) state <= ST_RUN;
            end
            default: state <= ST_IDLE;
         endcase

         if (jump_take) begin
            pc <= i_jump_addr;
         end else if (fetch) begin
            pc <= (WRAP && (pc == LAST)) ? 16'd0 : pc + 16'd1;
         end

         // Jump flushes the held word even if it is being accepted this cycle.
         if (jump_take) begin
            o_valid <= 1'b0;
         end else if (fetch) begin
            o_valid  <= 1'b1;
            o_instr  <= i_rom_data;
            o_pc_out <= pc;
         end else if (accept) begin
            o_valid <= 1'b0;
         end

         if (accept && (o_count != 16'hFFFF)) o_count <= o_count + 16'd1;
      end
   end

   // Class bits are numbered MSB-first: bit 0 of the instruction is o_instr[17].
   always_comb begin
      o_class = 2'b01;
      if (o_instr[17:16] == 2'b00)       o_class = 2'b00;
      else if (o_instr[17:15] == 3'b110) o_class = 2'b10;
      else if (o_instr[17:15] == 3'b111) o_class = 2'b11;
   end

   assign o_rom_addr = pc;
   assign o_done     = (state == ST_DONE) && !o_valid;
   assign dbg_state  = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one non-wrapping and one wrapping
// instance share stimulus, each reading its own view of a 6-word ROM.
module tb_fetch_sequencer;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic        clk = 1'b0;
   logic        rst, start, pause, jump, ready;
   logic [15:0] jump_addr;

   logic [15:0] a_addr, a_pc_out, a_count;
   logic [17:0] a_data, a_instr;
   logic [1:0]  a_class, a_state;
   logic        a_valid, a_done;

   logic [15:0] w_addr, w_pc_out, w_count;
   logic [17:0] w_data, w_instr;
   logic [1:0]  w_class, w_state;
   logic        w_valid, w_done;

   logic [17:0] rom [0:5];
   logic [1:0]  exp_cls [0:5];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   assign a_data = (a_addr < 16'd6) ? rom[a_addr[2:0]] : 18'd0;
   assign w_data = (w_addr < 16'd6) ? rom[w_addr[2:0]] : 18'd0;

   fetch_sequencer #(.PROG_LEN(6), .WRAP(1'b0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause),
      .i_jump(jump), .i_jump_addr(jump_addr), .o_rom_addr(a_addr),
      .i_rom_data(a_data), .o_instr(a_instr), .o_class(a_class),
      .o_valid(a_valid), .i_ready(ready), .o_pc_out(a_pc_out),
      .o_done(a_done), .o_count(a_count), .dbg_state(a_state)
   );

   fetch_sequencer #(.PROG_LEN(6), .WRAP(1'b1)) u_wrap (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause),
      .i_jump(jump), .i_jump_addr(jump_addr), .o_rom_addr(w_addr),
      .i_rom_data(w_data), .o_instr(w_instr), .o_class(w_class),
      .o_valid(w_valid), .i_ready(ready), .o_pc_out(w_pc_out),
      .o_done(w_done), .o_count(w_count), .dbg_state(w_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; jump = 1'b0;
      jump_addr = 16'd0; ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Pulse start; returns in cycle 1 (state RUN, nothing valid yet).
   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (a_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", a_state, ST_IDLE); end
      n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", a_valid); end
      n_tests++; if (a_instr !== 18'd0) begin n_fail++; $display("FAIL reset_instr: got %0h exp 0", a_instr); end
      n_tests++; if (a_class !== 2'b00) begin n_fail++; $display("FAIL reset_class: got %0b exp 00", a_class); end
      n_tests++; if (a_pc_out !== 16'd0) begin n_fail++; $display("FAIL reset_pc_out: got %0d exp 0", a_pc_out); end
      n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b exp 0", a_done); end
      n_tests++; if (a_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", a_count); end
      n_tests++; if (a_addr !== 16'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d exp 0", a_addr); end
      // Jump in IDLE is ignored.
      jump = 1'b1; jump_addr = 16'd4;
      tick();
      jump = 1'b0;
      n_tests++; if (a_addr !== 16'd0 || a_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_jump: got addr %0d state %0d exp 0/0", a_addr, a_state); end
   endtask

   task automatic test_stream();
      do_reset();
      ready = 1'b1;
      kick();
      n_tests++; if (a_valid !== 1'b0 || a_state !== ST_RUN) begin n_fail++; $display("FAIL stream_cycle1: got valid %0b state %0d exp 0/1", a_valid, a_state); end
      tick();
      for (int k = 0; k < 6; k++) begin
         n_tests++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b exp 1", k, a_valid); end
         n_tests++; if (a_pc_out !== 16'(k)) begin n_fail++; $display("FAIL stream_pc_out[%0d]: got %0d exp %0d", k, a_pc_out, k); end
         n_tests++; if (a_instr !== rom[k]) begin n_fail++; $display("FAIL stream_instr[%0d]: got %0h exp %0h", k, a_instr, rom[k]); end
         n_tests++; if (a_class !== exp_cls[k]) begin n_fail++; $display("FAIL stream_class[%0d]: got %0b exp %0b", k, a_class, exp_cls[k]); end
         n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL stream_done_early[%0d]: got %0b exp 0", k, a_done); end
         tick();
      end
      n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL stream_done: got %0b exp 1", a_done); end
      n_tests++; if (a_count !== 16'd6) begin n_fail++; $display("FAIL stream_count: got %0d exp 6", a_count); end
      n_tests++; if (a_state !== ST_DONE) begin n_fail++; $display("FAIL stream_state: got %0d exp %0d", a_state, ST_DONE); end
   endtask

   task automatic test_stall();
      int idx;
      do_reset();
      ready = 1'b1;
      kick();
      tick();
      tick();
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_tests++; if (a_instr !== rom[1] || a_pc_out !== 16'd1 || a_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got instr %0h pc_out %0d valid %0b exp %0h/1/1", k, a_instr, a_pc_out, a_valid, rom[1]); end
         n_tests++; if (a_addr !== 16'd2) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0d exp 2", k, a_addr); end
         if (k < 2) tick();
      end
      ready = 1'b1;
      idx = 1;
      for (int c = 0; c < 20 && !a_done; c++) begin
         if (a_valid) begin
            n_tests++; if (a_pc_out !== 16'(idx) || a_instr !== rom[idx % 6]) begin n_fail++; $display("FAIL stall_seq: got pc_out %0d instr %0h exp %0d", a_pc_out, a_instr, idx); end
            idx++;
         end
         tick();
      end
      n_tests++; if (idx !== 6) begin n_fail++; $display("FAIL stall_words: got %0d exp 6", idx); end
      n_tests++; if (a_count !== 16'd6) begin n_fail++; $display("FAIL stall_count: got %0d exp 6", a_count); end
   endtask

   task automatic test_jump();
      int idx;
      do_reset();
      ready = 1'b1;
      kick();
      tick();
      tick();
      ready = 1'b0;
      n_tests++; if (a_pc_out !== 16'd1 || a_valid !== 1'b1) begin n_fail++; $display("FAIL jump_pre: got pc_out %0d valid %0b exp 1/1", a_pc_out, a_valid); end
      jump = 1'b1; jump_addr = 16'd3;
      tick();
      jump = 1'b0;
      n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL jump_flush: got %0b exp 0", a_valid); end
      n_tests++; if (a_addr !== 16'd3) begin n_fail++; $display("FAIL jump_pc: got %0d exp 3", a_addr); end
      ready = 1'b1;
      idx = 3;
      for (int c = 0; c < 20 && !a_done; c++) begin
         if (a_valid) begin
            n_tests++; if (a_pc_out !== 16'(idx) || a_instr !== rom[idx % 6]) begin n_fail++; $display("FAIL jump_seq: got pc_out %0d instr %0h exp %0d", a_pc_out, a_instr, idx); end
            idx++;
         end
         tick();
      end
      n_tests++; if (idx !== 6) begin n_fail++; $display("FAIL jump_words: got %0d exp 6", idx); end
      n_tests++; if (a_count !== 16'd4) begin n_fail++; $display("FAIL jump_count: got %0d exp 4", a_count); end
   endtask

   task automatic test_pause();
      do_reset();
      ready = 1'b1;
      kick();
      tick();
      pause = 1'b1;
      tick();
      n_tests++; if (a_valid !== 1'b0 || a_addr !== 16'd1) begin n_fail++; $display("FAIL pause_accept: got valid %0b addr %0d exp 0/1", a_valid, a_addr); end
      tick();
      n_tests++; if (a_valid !== 1'b0 || a_addr !== 16'd1) begin n_fail++; $display("FAIL pause_freeze: got valid %0b addr %0d exp 0/1", a_valid, a_addr); end
      pause = 1'b0;
      tick();
      n_tests++; if (a_valid !== 1'b1 || a_pc_out !== 16'd1) begin n_fail++; $display("FAIL pause_resume: got valid %0b pc_out %0d exp 1/1", a_valid, a_pc_out); end
      n_tests++; if (a_count !== 16'd1) begin n_fail++; $display("FAIL pause_count: got %0d exp 1", a_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      ready = 1'b1;
      kick();
      tick();
      for (int k = 0; k < 14; k++) begin
         n_tests++; if (w_valid !== 1'b1 || w_pc_out !== 16'(k % 6)) begin n_fail++; $display("FAIL wrap_seq[%0d]: got valid %0b pc_out %0d exp 1/%0d", k, w_valid, w_pc_out, k % 6); end
         n_tests++; if (w_instr !== rom[k % 6] || w_done !== 1'b0) begin n_fail++; $display("FAIL wrap_word[%0d]: got instr %0h done %0b exp %0h/0", k, w_instr, w_done, rom[k % 6]); end
         tick();
      end
      n_tests++; if (w_count !== 16'd14) begin n_fail++; $display("FAIL wrap_count: got %0d exp 14", w_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b1;
      kick();
      tick(); tick(); tick(); tick();
      n_tests++; if (a_addr !== 16'd4 || a_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got addr %0d valid %0b exp 4/1", a_addr, a_valid); end
      rst = 1'b1; jump = 1'b1; jump_addr = 16'd2;
      tick();
      rst = 1'b0; jump = 1'b0;
      n_tests++; if (a_state !== ST_IDLE || a_addr !== 16'd0) begin n_fail++; $display("FAIL mid_state: got state %0d addr %0d exp 0/0", a_state, a_addr); end
      n_tests++; if (a_valid !== 1'b0 || a_instr !== 18'd0 || a_pc_out !== 16'd0) begin n_fail++; $display("FAIL mid_outputs: got valid %0b instr %0h pc_out %0d exp 0/0/0", a_valid, a_instr, a_pc_out); end
      n_tests++; if (a_count !== 16'd0 || a_done !== 1'b0 || a_class !== 2'b00) begin n_fail++; $display("FAIL mid_misc: got count %0d done %0b class %0b exp 0/0/00", a_count, a_done, a_class); end
      kick();
      tick();
      n_tests++; if (a_valid !== 1'b1 || a_pc_out !== 16'd0 || a_instr !== rom[0]) begin n_fail++; $display("FAIL mid_restart: got valid %0b pc_out %0d instr %0h exp 1/0/%0h", a_valid, a_pc_out, a_instr, rom[0]); end
   endtask

   task automatic run_to_done();
      int c;
      do_reset();
      ready = 1'b1;
      kick();
      c = 0;
      while (!a_done && c < 30) begin
         tick();
         c++;
      end
      n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: got done %0b after %0d cycles exp 1", a_done, c); end
   endtask

   task automatic test_done_jump();
      run_to_done();
      jump = 1'b1; jump_addr = 16'd0;
      tick();
      jump = 1'b0;
      n_tests++; if (a_state !== ST_RUN || a_addr !== 16'd0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL djump0_run: got state %0d addr %0d valid %0b exp 1/0/0", a_state, a_addr, a_valid); end
      tick();
      n_tests++; if (a_valid !== 1'b1 || a_pc_out !== 16'd0 || a_done !== 1'b0) begin n_fail++; $display("FAIL djump0_fetch: got valid %0b pc_out %0d done %0b exp 1/0/0", a_valid, a_pc_out, a_done); end

      run_to_done();
      jump = 1'b1; jump_addr = 16'd9;
      tick();
      jump = 1'b0;
      n_tests++; if (a_state !== ST_RUN || a_addr !== 16'd9 || a_valid !== 1'b0) begin n_fail++; $display("FAIL djump9_run: got state %0d addr %0d valid %0b exp 1/9/0", a_state, a_addr, a_valid); end
      tick();
      n_tests++; if (a_state !== ST_DONE || a_done !== 1'b1 || a_valid !== 1'b0) begin n_fail++; $display("FAIL djump9_done: got state %0d done %0b valid %0b exp 2/1/0", a_state, a_done, a_valid); end
      n_tests++; if (a_count !== 16'd6 || a_addr !== 16'd9) begin n_fail++; $display("FAIL djump9_nofetch: got count %0d addr %0d exp 6/9", a_count, a_addr); end
   endtask

   initial begin
      rom[0] = 18'b000000000010000001; exp_cls[0] = 2'b00;
      rom[1] = 18'b110010100000000000; exp_cls[1] = 2'b10;
      rom[2] = 18'b110001000000000000; exp_cls[2] = 2'b10;
      rom[3] = 18'd127;                exp_cls[3] = 2'b00;
      rom[4] = 18'b111010010000000000; exp_cls[4] = 2'b11;
      rom[5] = 18'b110001000000000000; exp_cls[5] = 2'b10;
      rst = 1'b1; start = 1'b0; pause = 1'b0; jump = 1'b0;
      jump_addr = 16'd0; ready = 1'b0;
      #2;
      test_reset();
      test_stream();
      test_stall();
      test_jump();
      test_pause();
      test_wrap();
      test_reset_mid();
      test_done_jump();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program ROM: owns the program counter, drives the ROM address, and registers each 18-bit instruction into a one-entry output stage.
- Delivers instructions to the execute stage over a valid/ready handshake, together with a pre-decoded instruction class.
- Supports start, pause, jump (with flush), end-of-program detection and optional wrap-around.
- Sits between the program ROM (combinational read) and the instruction decoder/execute unit.

Parameters:
- PROG_LEN, 7: number of valid ROM words; addresses 0..PROG_LEN-1 are fetchable.
- WRAP, 0: 1 = PC wraps to 0 after PROG_LEN-1 and execution continues; 0 = stop at end.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  leaves IDLE and begins fetching at PC=0.
- i_pause  input  1  while high, no new fetch; held output is kept.
- i_jump  input  1  single-cycle redirect request.
- i_jump_addr  input  16  jump target.
- o_rom_addr  output  16  ROM address; always equals PC.
- i_rom_data  input  18  ROM word at o_rom_addr, same cycle.
- o_instr  output  18  registered instruction.
- o_class  output  2  decode of o_instr: 00 = DT (bits[0:1]=00), 10 = MV (bits[0:2]=110), 11 = OP (bits[0:2]=111), 01 = RSV (any other pattern).
- o_valid  output  1  o_instr/o_class hold a valid instruction.
- i_ready  input  1  execute stage accepts when o_valid & i_ready.
- o_pc_out  output  16  ROM address o_instr was fetched from.
- o_done  output  1  program finished and output stage empty.
- o_count  output  16  accepted-instruction count; saturates at 16'hFFFF.

Behaviour:
- Reset values: state=IDLE, PC=0, o_valid=0, o_instr=0, o_class=00, o_pc_out=0, o_done=0, o_count=0. Reset overrides every other input, including mid-fetch and mid-jump.
- States:
  - IDLE: waits for i_start, then goes to RUN. i_jump is ignored in IDLE.
  - RUN: fetches instructions.
  - DONE: entered from RUN when PC >= PROG_LEN and WRAP=0.
- fetch = (state==RUN) & !i_pause & !i_jump & (PC < PROG_LEN) & (!o_valid | i_ready).
- On fetch:
  - o_instr <= i_rom_data; o_pc_out <= PC; o_valid <= 1.
  - PC <= PC+1, except PC <= 0 when PC==PROG_LEN-1 and WRAP=1.
- Handshake:
  - Accept (o_valid & i_ready) without a same-cycle fetch: o_valid <= 0.
  - Accept with a same-cycle fetch: the new word replaces the old one. This gives full throughput, one instruction per cycle.
  - o_count increments on every accept, independent of pause.
- Timing: fetch in cycle N gives o_valid=1 in cycle N+1. From i_start in cycle 0, the state is RUN in cycle 1 and word 0 is valid in cycle 2.
- Jump (state RUN or DONE):
  - PC <= i_jump_addr; o_valid <= 0 (flush, even when i_ready=1 in that cycle); no fetch that cycle.
  - From DONE, state returns to RUN.
  - If the target is >= PROG_LEN, RUN goes to DONE next cycle with nothing fetched.
  - Jump has priority over pause and fetch.
- Pause: o_valid and o_instr are held. An accept during pause still clears o_valid. PC is frozen.
- DONE: no fetches. The pending instruction can still be accepted. o_done = (state==DONE) & !o_valid. Only a jump or reset leaves DONE.
- Arithmetic: PC is 16-bit unsigned and is never incremented past PROG_LEN.

Test Plan:
- ROM = {DT 129 (18'b000000000010000001), MV 110010100000000000, MV 110001000000000000, DT 127, OP 111010010000000000, MV 110001000000000000}, PROG_LEN=6, WRAP=0, i_ready=1, pulse i_start:
  - o_valid rises 2 cycles after start.
  - Stream of 6 instructions with o_class 00,10,10,00,11,10.
  - o_pc_out 0..5; o_count=6.
  - o_done=1 one cycle after the last accept.
- Same program, i_ready low for 3 cycles while word 1 is held -> o_instr stays 110010100000000000, PC stays 2, no word is skipped or duplicated, and o_count ends at 6.
- i_jump with i_jump_addr=3 while word 1 is valid and i_ready=0 -> word 1 is dropped; the next outputs are o_pc_out=3 (DT 127), then 4, then 5.
- WRAP=1, run 14 accepts -> o_pc_out sequence 0..5,0..5,0,1; o_done never asserts.
- Reset asserted mid-stream (o_valid=1, PC=4) -> next cycle all outputs are at reset values and the state is IDLE; i_start restarts from PC=0.
- In DONE, i_jump with i_jump_addr=0 -> state returns to RUN and word 0 is fetched. In a separate run, i_jump with i_jump_addr=9 -> DONE with no fetch and o_done=1.
